// File: rtl/four_bit_adder.sv
`default_nettype none
// ============================================================================
//  Module   : four_bit_adder
//  Purpose  : Registered 4-bit unsigned adder. A ripple-carry chain of four
//             full-adder cells (carry-in tied low) forms v1 + v2. The 5-bit
//             result and the carry-out are captured on the rising clock edge.
//  Ports    :
//    clk        in   1  clock, rising-edge active
//    rst        in   1  asynchronous, active-high reset (clears sum and cout)
//    v1         in   4  unsigned operand A
//    v2         in   4  unsigned operand B
//    sum        out  5  registered v1 + v2 (bit 4 is the carry)
//    cout       out  1  registered carry-out of bit 3 (always equals sum[4])
//  Revision : 1.0  initial release
// ============================================================================
module four_bit_adder (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] v1,
  input  logic [3:0] v2,
  output logic [4:0] sum,
  output logic       cout
);

  // w_carry[i] is the carry into bit i; w_carry[4] is the carry out of bit 3.
  logic [4:0] w_carry;
  logic [3:0] w_sum_bits;
  logic [4:0] w_result;

  logic [4:0] r_sum;
  logic       r_cout;

  assign w_carry[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fa
      // Propagate term is shared by the sum bit and the carry equation.
      logic w_p;
      assign w_p              = v1[gi] ^ v2[gi];
      assign w_sum_bits[gi]   = w_p ^ w_carry[gi];
      assign w_carry[gi + 1]  = (v1[gi] & v2[gi]) | (w_carry[gi] & w_p);
    end
  endgenerate

  assign w_result = {w_carry[4], w_sum_bits};

  // Both registers load from the same carry net, so cout tracks sum[4]
  // in every cycle, and both clear together on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum  <= 5'd0;
      r_cout <= 1'b0;
    end else begin
      r_sum  <= w_result;
      r_cout <= w_carry[4];
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_four_bit_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_four_bit_adder
//  Purpose  : Scoreboard bench for four_bit_adder. The driver pushes the
//             expected result when it applies operands; the monitor pops and
//             compares one cycle later. Reset behaviour is checked inline.
//  Revision : 1.0  initial release
// ============================================================================
module tb_four_bit_adder;

  logic       clk;
  logic       rst;
  logic [3:0] v1;
  logic [3:0] v2;
  logic [4:0] sum;
  logic       cout;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] exp_sum;
    logic       exp_cout;
  } sb_entry_t;

  sb_entry_t sb[$];

  int checks = 0;
  int errors = 0;

  four_bit_adder dut (
    .clk  (clk),
    .rst  (rst),
    .v1   (v1),
    .v2   (v2),
    .sum  (sum),
    .cout (cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver: applies operands on the falling edge and records expectations.
  task automatic drive(input logic [3:0] a, input logic [3:0] b,
                       input logic [4:0] es, input logic ec);
    sb_entry_t e;
    @(negedge clk);
    v1 = a;
    v2 = b;
    e.a = a;
    e.b = b;
    e.exp_sum = es;
    e.exp_cout = ec;
    sb.push_back(e);
  endtask

  // Monitor: the result of operands applied before an edge is valid just
  // after that edge.
  initial begin
    sb_entry_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && sb.size() > 0) begin
        e = sb.pop_front();
        chk($sformatf("sum %0d+%0d", e.a, e.b), sum, e.exp_sum);
        chk($sformatf("cout %0d+%0d", e.a, e.b), {4'd0, cout}, {4'd0, e.exp_cout});
        chk($sformatf("cout==sum4 %0d+%0d", e.a, e.b), {4'd0, cout}, {4'd0, sum[4]});
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  // Directed vectors with hand-computed results.
  logic [3:0] dir_a   [8] = '{4'd0, 4'd15, 4'd8,  4'd15, 4'd7,  4'd5,  4'd1,  4'd9};
  logic [3:0] dir_b   [8] = '{4'd0, 4'd0,  4'd8,  4'd15, 4'd9,  4'd10, 4'd14, 4'd6};
  logic [4:0] dir_sum [8] = '{5'd0, 5'd15, 5'd16, 5'd30, 5'd16, 5'd15, 5'd15, 5'd15};
  logic       dir_cout[8] = '{1'b0, 1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0};

  initial begin
    logic [4:0] last_exp;
    rst = 1'b0;
    v1  = 4'd0;
    v2  = 4'd0;

    // Reset asserted before any clock edge must clear outputs on its own.
    #2 rst = 1'b1;
    #1;
    chk("reset sum", sum, 5'd0);
    chk("reset cout", {4'd0, cout}, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset held sum", sum, 5'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      drive(dir_a[i], dir_b[i], dir_sum[i], dir_cout[i]);

    // Exhaustive sweep; also confirms sum holds while operands change
    // between edges.
    last_exp = dir_sum[7];
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [4:0] s;
        s = 5'(a) + 5'(b);
        drive(4'(a), 4'(b), s, (a + b) > 15);
        #1;
        chk("hold between edges", sum, last_exp);
        last_exp = s;
      end
    end

    // Mid-operation reset with sum = 30 held.
    drive(4'd15, 4'd15, 5'd30, 1'b1);
    @(posedge clk);
    #3;
    chk("pre-reset sum", sum, 5'd30);
    rst = 1'b1;
    #1;
    chk("async reset sum", sum, 5'd0);
    chk("async reset cout", {4'd0, cout}, 5'd0);
    @(posedge clk);
    #1;
    chk("reset over edge sum", sum, 5'd0);

    // Release with 3 + 4 applied; first edge loads normally.
    @(negedge clk);
    v1 = 4'd3;
    v2 = 4'd4;
    begin
      sb_entry_t e;
      e.a = 4'd3;
      e.b = 4'd4;
      e.exp_sum = 5'd7;
      e.exp_cout = 1'b0;
      sb.push_back(e);
    end
    rst = 1'b0;

    repeat (3) @(negedge clk);
    chk("scoreboard drained", 5'(sb.size()), 5'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
